pll_reset_seq: RTL and testbench
================================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The block SHALL expose parameter NUM_DOMAINS, default 2, the number of independent system-reset outputs (1..8).
REQ-002 The block SHALL expose parameter PLL_RST_CYCLES, default 16, the cycles the PLL reset is held asserted per attempt.
REQ-003 The block SHALL expose parameter LOCK_STABLE_CYCLES, default 256, the consecutive synchronized-lock cycles required before release.
REQ-004 The block SHALL expose parameter LOCK_TIMEOUT_CYCLES, default 65536, the cycles allowed in WAIT_LOCK before a retry.
REQ-005 The block SHALL expose parameter STAGGER_CYCLES, default 8, the spacing between successive domain reset releases.
REQ-006 The block SHALL expose parameter MAX_RETRIES, default 3, the timeouts tolerated before entering FAULT.
REQ-007 clk  input  1  reference clock (HSOSC); the block's only clock.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 pll_lock  input  1  raw PLL LOCK, asynchronous to clk.
REQ-010 pll_rst_n  output  1  drives PLL RESET_N; low = PLL held in reset.
REQ-011 sys_rst_n  output  NUM_DOMAINS  per-domain active-low system resets.
REQ-012 ready  output  1  high when every domain is released and lock is good.
REQ-013 fault  output  1  sticky; high when retries are exhausted.
REQ-014 retry_cnt  output  $clog2(MAX_RETRIES+1)  timeouts in the current bring-up.
REQ-015 lock_loss_cnt  output  8  count of lock losses seen in RUN (see Configuration).

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchronizer (lock_s); all decisions SHALL use lock_s only.
REQ-017 All outputs SHALL be registered; FSM states SHALL be PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
REQ-018 PLL_RESET: pll_rst_n=0 and all sys_rst_n=0; after PLL_RST_CYCLES cycles the FSM SHALL go to WAIT_LOCK with pll_rst_n=1.
REQ-019 WAIT_LOCK: on lock_s=1 the FSM SHALL go to STABLE; on the timer reaching LOCK_TIMEOUT_CYCLES it SHALL go to FAULT if retry_cnt==MAX_RETRIES, else increment retry_cnt and go to PLL_RESET.
REQ-020 On entry to WAIT_LOCK the timeout timer SHALL restart at 0.
REQ-021 STABLE: after LOCK_STABLE_CYCLES consecutive lock_s=1 cycles the FSM SHALL go to RELEASE; any lock_s=0 SHALL return it to WAIT_LOCK.
REQ-022 RELEASE: sys_rst_n[i] SHALL rise exactly STAGGER_CYCLES*(i+1) cycles after RELEASE entry and stay high; after sys_rst_n[NUM_DOMAINS-1] rises, the FSM SHALL go to RUN.
REQ-023 RUN: ready=1 and retry_cnt SHALL clear to 0.
REQ-024 When lock_s=0 in RELEASE or RUN, all sys_rst_n SHALL go low and ready low on the next edge, simultaneously, and the FSM SHALL go to PLL_RESET without incrementing retry_cnt.
REQ-025 FAULT SHALL be terminal until rst_n: pll_rst_n=0, all sys_rst_n=0, ready=0, fault=1; pll_lock is ignored.
REQ-026 Counters SHALL be sized with $clog2 of their maximum values and SHALL never wrap within a state.

Reset
REQ-027 Asserting rst_n SHALL immediately force state=PLL_RESET, pll_rst_n=0, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0, and all timers=0, including mid-RELEASE and from FAULT.
REQ-028 Deassertion SHALL be glitch-free; the sequence SHALL restart from PLL_RESET on the first clk edge after release.

Configuration
REQ-029 With PLL_RESET_SEQ_LOCK_LOSS_CNT_EN defined, lock_loss_cnt SHALL increment, saturating at 255, on each RUN-to-PLL_RESET transition.
REQ-030 Without PLL_RESET_SEQ_LOCK_LOSS_CNT_EN, lock_loss_cnt SHALL be tied to 0, no counter logic SHALL be instantiated, and all other behaviour SHALL be identical.

Verification (NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, STAGGER_CYCLES=2, MAX_RETRIES=1)
REQ-031 Clean bring-up: pll_lock high from reset release -> pll_rst_n high after 4 cycles; sys_rst_n[0..2] rise 2/4/6 cycles after RELEASE entry; ready=1 with sys_rst_n[2].
REQ-032 Lock never asserts -> two 32-cycle timeouts with retry_cnt 0->1, then fault=1, pll_rst_n=0, and state holds through 100 further cycles.
REQ-033 Lock glitch low 1 cycle at STABLE count 5 -> return to WAIT_LOCK, stability count restarts, and release occurs 8 clean cycles later.
REQ-034 Lock drops in RUN -> all sys_rst_n low and ready low on the same edge, lock_loss_cnt=1 (macro on) or 0 (macro off), and the sequence recovers when lock returns.
REQ-035 rst_n asserted mid-RELEASE after sys_rst_n[0] has risen -> all outputs return to reset values asynchronously, and the full sequence reruns on release.

Source files
------------

// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: PLL reset pulse, lock wait with timeout/retry, lock-stability filter, staggered domain releases.
// Optional feature: define PLL_RESET_SEQ_LOCK_LOSS_CNT_EN to count lock losses seen in RUN (saturating at 255).
module pll_reset_seq #(
  parameter int NUM_DOMAINS         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGGER_CYCLES      = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pll_lock,
  output logic                               pll_rst_n,
  output logic [NUM_DOMAINS-1:0]             sys_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [7:0]                         lock_loss_cnt
);

  localparam int RW          = $clog2(MAX_RETRIES + 1);
  localparam int REL_CYCLES  = STAGGER_CYCLES * NUM_DOMAINS;
  localparam int TMAX_A      = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int TMAX_B      = (LOCK_TIMEOUT_CYCLES > REL_CYCLES) ? LOCK_TIMEOUT_CYCLES : REL_CYCLES;
  localparam int TMAX        = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW          = $clog2(TMAX + 1);

  localparam logic [TW-1:0] PLL_RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] RELEASE_LAST = TW'(REL_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [1:0]             sync_q;
  logic                   lock_s;
  logic                   pll_rst_n_q, pll_rst_n_d;
  logic [NUM_DOMAINS-1:0] sys_rst_n_q, sys_rst_n_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    unique case (state_q)
      PLL_RESET: begin
        if (timer_q == PLL_RST_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = FAULT;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = PLL_RESET;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RELEASE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d = PLL_RESET;
          timer_d = '0;
        end else if (timer_q == RELEASE_LAST) begin
          state_d = RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = PLL_RESET;
          timer_d = '0;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = PLL_RESET;
        timer_d = '0;
      end
    endcase
    if (state_d == RUN) retry_d = '0;
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    pll_rst_n_d = (state_d inside {WAIT_LOCK, STABLE, RELEASE, RUN});
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
    sys_rst_n_d = '0;
    if (state_d == RUN) begin
      sys_rst_n_d = '1;
    end else if (state_d == RELEASE) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        sys_rst_n_d[i] = (timer_d >= TW'(STAGGER_CYCLES * (i + 1)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RESET;
      timer_q     <= '0;
      retry_q     <= '0;
      sync_q      <= '0;
      pll_rst_n_q <= 1'b0;
      sys_rst_n_q <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      sync_q      <= {sync_q[0], pll_lock};
      pll_rst_n_q <= pll_rst_n_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

`ifdef PLL_RESET_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_q, lock_loss_d;

  always_comb begin
    lock_loss_d = lock_loss_q;
    if ((state_q == RUN) && (state_d == PLL_RESET) && (lock_loss_q != 8'hFF)) begin
      lock_loss_d = lock_loss_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_q <= 8'h00;
    end else begin
      lock_loss_q <= lock_loss_d;
    end
  end

  assign lock_loss_cnt = lock_loss_q;
`else
  assign lock_loss_cnt = 8'h00;
`endif

  assign pll_rst_n = pll_rst_n_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq: a phase/elapsed-time model checked every cycle, plus hand-computed event timings.
module tb_pll_reset_seq;

  localparam int NUM_DOMAINS         = 3;
  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int LOCK_TIMEOUT_CYCLES = 32;
  localparam int STAGGER_CYCLES      = 2;
  localparam int MAX_RETRIES         = 1;

`ifdef PLL_RESET_SEQ_LOCK_LOSS_CNT_EN
  localparam int LOSS_AFTER_ONE_DROP = 1;
`else
  localparam int LOSS_AFTER_ONE_DROP = 0;
`endif

  localparam int PH_RST = 0, PH_WAIT = 1, PH_STABLE = 2, PH_REL = 3, PH_RUN = 4, PH_FAULT = 5;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_rst_n;
  logic [2:0] sys_rst_n;
  logic       ready;
  logic       fault;
  logic [0:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  int ph = PH_RST;
  int age = 0;
  int mRetry = 0;
  int mLoss = 0;
  bit m1 = 1'b0;
  bit m2 = 1'b0;

  int riseP, riseR, riseF, riseRetry;
  int riseS [3];

  always #5 clk = ~clk;

  pll_reset_seq #(
    .NUM_DOMAINS(NUM_DOMAINS),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
    .STAGGER_CYCLES(STAGGER_CYCLES),
    .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_lock(pll_lock),
    .pll_rst_n(pll_rst_n),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model tracks the phase and cycles elapsed in it; lock is seen two edges late.
  always @(posedge clk or negedge rst_n) begin : modelProc
    int p, a, r, l;
    bit lockS;
    if (!rst_n) begin
      ph <= PH_RST; age <= 0; mRetry <= 0; mLoss <= 0; m1 <= 1'b0; m2 <= 1'b0;
    end else begin
      p = ph; a = age; r = mRetry; l = mLoss; lockS = m2;
      case (p)
        PH_RST: begin
          a++;
          if (a == PLL_RST_CYCLES) begin p = PH_WAIT; a = 0; end
        end
        PH_WAIT: begin
          if (lockS) begin
            p = PH_STABLE; a = 0;
          end else begin
            a++;
            if (a == LOCK_TIMEOUT_CYCLES) begin
              a = 0;
              if (r == MAX_RETRIES) p = PH_FAULT;
              else begin r++; p = PH_RST; end
            end
          end
        end
        PH_STABLE: begin
          if (!lockS) begin p = PH_WAIT; a = 0; end
          else begin
            a++;
            if (a == LOCK_STABLE_CYCLES) begin p = PH_REL; a = 0; end
          end
        end
        PH_REL: begin
          if (!lockS) begin p = PH_RST; a = 0; end
          else begin
            a++;
            if (a == STAGGER_CYCLES * NUM_DOMAINS) begin p = PH_RUN; a = 0; r = 0; end
          end
        end
        PH_RUN: begin
          if (!lockS) begin
            p = PH_RST; a = 0;
            if (LOSS_AFTER_ONE_DROP == 1 && l < 255) l++;
          end
        end
        default: ;
      endcase
      ph <= p; age <= a; mRetry <= r; mLoss <= l;
      m2 <= m1; m1 <= pll_lock;
    end
  end

  always @(negedge clk) begin : compareProc
    logic [2:0] expSys;
    if (checkEn) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        expSys[i] = (ph == PH_RUN) || (ph == PH_REL && age >= STAGGER_CYCLES * (i + 1));
      end
      checkOutput("model pll_rst_n", pll_rst_n,
                  (ph == PH_WAIT || ph == PH_STABLE || ph == PH_REL || ph == PH_RUN) ? 1 : 0);
      checkOutput("model sys_rst_n", sys_rst_n, expSys);
      checkOutput("model ready", ready, (ph == PH_RUN) ? 1 : 0);
      checkOutput("model fault", fault, (ph == PH_FAULT) ? 1 : 0);
      checkOutput("model retry_cnt", retry_cnt, mRetry);
      checkOutput("model lock_loss_cnt", lock_loss_cnt, mLoss);
    end
  end

  // Holds reset for a few cycles with the given lock level, then releases on a falling clock edge.
  task automatic applyStimulus(input bit lockLevel);
    @(negedge clk);
    rst_n = 1'b0;
    pll_lock = lockLevel;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Records the first sampled cycle (1 = after the first rising edge) at which each output is high.
  task automatic traceRise(input int ncyc);
    riseP = -1; riseR = -1; riseF = -1; riseRetry = -1;
    for (int i = 0; i < 3; i++) riseS[i] = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (riseP < 0 && pll_rst_n === 1'b1) riseP = c;
      for (int i = 0; i < 3; i++) if (riseS[i] < 0 && sys_rst_n[i] === 1'b1) riseS[i] = c;
      if (riseR < 0 && ready === 1'b1) riseR = c;
      if (riseF < 0 && fault === 1'b1) riseF = c;
      if (riseRetry < 0 && retry_cnt === 1'b1) riseRetry = c;
    end
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput({tag, " pll_rst_n"}, pll_rst_n, 0);
    checkOutput({tag, " sys_rst_n"}, sys_rst_n, 0);
    checkOutput({tag, " ready"}, ready, 0);
    checkOutput({tag, " fault"}, fault, 0);
    checkOutput({tag, " retry_cnt"}, retry_cnt, 0);
    checkOutput({tag, " lock_loss_cnt"}, lock_loss_cnt, 0);
  endtask

  initial begin
    int n;
    pll_lock = 1'b1;
    @(negedge clk);
    checkEn = 1'b1;
    checkAllReset("reset");

    $display("[TB] clean bring-up");
    applyStimulus(1'b1);
    traceRise(25);
    checkOutput("clean pll rise cycle", riseP, 4);
    checkOutput("clean sys0 rise cycle", riseS[0], 15);
    checkOutput("clean sys1 rise cycle", riseS[1], 17);
    checkOutput("clean sys2 rise cycle", riseS[2], 19);
    checkOutput("clean ready rise cycle", riseR, 19);

    $display("[TB] lock loss in RUN");
    pll_lock = 1'b0;
    n = 0;
    while (ready === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("loss ready fall latency", n, 3);
    checkOutput("loss sys_rst_n", sys_rst_n, 0);
    checkOutput("loss pll_rst_n", pll_rst_n, 0);
    checkOutput("loss lock_loss_cnt", lock_loss_cnt, LOSS_AFTER_ONE_DROP);
    pll_lock = 1'b1;
    traceRise(30);
    checkOutput("recover pll rise cycle", riseP, 4);
    checkOutput("recover sys0 rise cycle", riseS[0], 15);
    checkOutput("recover ready rise cycle", riseR, 19);

    $display("[TB] async reset mid-RELEASE");
    applyStimulus(1'b1);
    traceRise(16);
    checkOutput("midrel sys0 risen", riseS[0], 15);
    checkOutput("midrel sys1 still low", sys_rst_n[1], 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkAllReset("midrel async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    traceRise(25);
    checkOutput("rerun pll rise cycle", riseP, 4);
    checkOutput("rerun sys0 rise cycle", riseS[0], 15);
    checkOutput("rerun ready rise cycle", riseR, 19);

    $display("[TB] lock glitch in STABLE");
    applyStimulus(1'b1);
    fork
      traceRise(30);
      begin
        repeat (8) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
      end
    join
    checkOutput("glitch pll rise cycle", riseP, 4);
    checkOutput("glitch sys0 rise cycle", riseS[0], 22);
    checkOutput("glitch sys2 rise cycle", riseS[2], 26);
    checkOutput("glitch ready rise cycle", riseR, 26);

    $display("[TB] lock never asserts");
    applyStimulus(1'b0);
    traceRise(80);
    checkOutput("nolock pll rise cycle", riseP, 4);
    checkOutput("nolock retry rise cycle", riseRetry, 36);
    checkOutput("nolock fault rise cycle", riseF, 72);
    checkOutput("nolock ready never", riseR, -1);
    pll_lock = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("fault held", fault, 1);
    checkOutput("fault pll_rst_n", pll_rst_n, 0);
    checkOutput("fault sys_rst_n", sys_rst_n, 0);
    checkOutput("fault ready", ready, 0);

    $display("[TB] async reset from FAULT");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllReset("fault async");
    @(negedge clk);
    rst_n = 1'b1;
    traceRise(25);
    checkOutput("postfault ready rise cycle", riseR, 19);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
